// File: rtl/pcm_decode_if.sv
// Serial PCM code-bit input plus the valid/ready linear-sample output of the
// receive-side PCM expander.
interface pcm_decode_if;
   logic        bit_in;
   logic        bit_valid;
   logic        frame_start;
   logic        out_ready;
   logic        out_valid;
   logic [7:0]  pcm_code;
   logic [12:0] lin_out;
   logic        overrun;

   modport master (
      output bit_in, bit_valid, frame_start, out_ready,
      input  out_valid, pcm_code, lin_out, overrun
   );

   modport slave (
      input  bit_in, bit_valid, frame_start, out_ready,
      output out_valid, pcm_code, lin_out, overrun
   );
endinterface

// File: rtl/pcm_decode.sv
// Receive-side PCM expander: assembles serial code bits into 8-bit words, expands
// them to 13-bit sign-magnitude samples and holds them on a valid/ready output.
module pcm_decode #(
   parameter int MSB_FIRST   = 1,
   parameter int INVERT_EVEN = 0
) (
   input  logic         clkAD,
   input  logic         reset,
   pcm_decode_if.slave  bus
);

   localparam logic [7:0] INV_MASK = (INVERT_EVEN != 0) ? 8'h55 : 8'h00;

   function automatic logic [12:0] expand(input logic [7:0] c);
      logic [2:0]  s;
      logic [3:0]  m;
      logic [11:0] mag;
      s = c[6:4];
      m = c[3:0];
      if (s == 3'd0) begin
         mag = {7'd0, m, 1'b1};
      end else begin
         mag = {6'd0, 1'b1, m, 1'b1} << (s - 3'd1);
      end
      return {c[7], mag};
   endfunction

   logic [7:0]  asm_q, asm_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        done_q, done_d;
   logic [7:0]  word_q, word_d;
   logic        vld_q, vld_d;
   logic [7:0]  code_q, code_d;
   logic [12:0] lin_q, lin_d;
   logic        ovr_q, ovr_d;

   logic [2:0]  pos_cnt;
   logic [2:0]  bit_idx;

   // Assembly stage: a frame_start bit restarts the word at count 0.
   always_comb begin
      asm_d   = asm_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      word_d  = word_q;
      pos_cnt = (bus.bit_valid && bus.frame_start) ? 3'd0 : cnt_q;
      bit_idx = (MSB_FIRST != 0) ? (3'd7 - pos_cnt) : pos_cnt;
      if (bus.bit_valid) begin
         asm_d          = (pos_cnt == 3'd0) ? 8'h00 : asm_q;
         asm_d[bit_idx] = bus.bit_in;
         if (pos_cnt == 3'd7) begin
            done_d = 1'b1;
            word_d = asm_d ^ INV_MASK;
            cnt_d  = 3'd0;
         end else begin
            cnt_d  = pos_cnt + 3'd1;
         end
      end
   end

   // Output stage: a completed word loads unless the held one is stuck.
   always_comb begin
      vld_d  = vld_q;
      code_d = code_q;
      lin_d  = lin_q;
      ovr_d  = ovr_q;
      if (done_q) begin
         if (vld_q && !bus.out_ready) begin
            ovr_d = 1'b1;
         end else begin
            vld_d  = 1'b1;
            code_d = word_q;
            lin_d  = expand(word_q);
         end
      end else if (vld_q && bus.out_ready) begin
         vld_d = 1'b0;
      end
   end

   always_ff @(posedge clkAD) begin
      if (!reset) begin
         asm_q  <= 8'h00;
         cnt_q  <= 3'd0;
         done_q <= 1'b0;
         word_q <= 8'h00;
         vld_q  <= 1'b0;
         code_q <= 8'h00;
         lin_q  <= 13'h0000;
         ovr_q  <= 1'b0;
      end else begin
         asm_q  <= asm_d;
         cnt_q  <= cnt_d;
         done_q <= done_d;
         word_q <= word_d;
         vld_q  <= vld_d;
         code_q <= code_d;
         lin_q  <= lin_d;
         ovr_q  <= ovr_d;
      end
   end

   assign bus.out_valid = vld_q;
   assign bus.pcm_code  = code_q;
   assign bus.lin_out   = lin_q;
   assign bus.overrun   = ovr_q;

endmodule
